// File: rtl/button_debounce_multi_pkg.sv
// Shared types and elaboration helpers for the multi-channel button debouncer.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      PRESSED    = 2'd2,
      RELEASE_DB = 2'd3
   } btn_state_t;

   // Smallest w with 2**w >= value (0 for value <= 1).
   function automatic int clog2_width(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/button_debounce_multi_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, long-press timer
// and registered level/strobe outputs.
module debounce_channel
   import btn_pkg::*;
#(
   parameter int DB_CYCLES   = 4,
   parameter int LONG_CYCLES = 10,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int   CW      = clog2_width(DB_CYCLES) + 1;
   localparam int   LW      = clog2_width(LONG_CYCLES) + 1;
   localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic          sync1_r;
   logic          sync2_r;
   logic          pressed_s;
   btn_state_t    state_r;
   logic [CW-1:0] cnt_r;
   logic [LW-1:0] lcnt_r;
   logic          long_fired_r;
   logic          level_r;
   logic          press_r;
   logic          release_r;
   logic          long_r;

   assign pressed_s = sync2_r ^ REL_LVL;

   // Bring the asynchronous pin into the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= REL_LVL;
         sync2_r <= REL_LVL;
      end else begin
         sync1_r <= btn_in;
         sync2_r <= sync1_r;
      end
   end

   // Debounce state machine with long-press detection; strobes default low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         lcnt_r       <= '0;
         long_fired_r <= 1'b0;
         level_r      <= 1'b0;
         press_r      <= 1'b0;
         release_r    <= 1'b0;
         long_r       <= 1'b0;
      end else begin
         press_r   <= 1'b0;
         release_r <= 1'b0;
         long_r    <= 1'b0;
         case (state_r)
            IDLE: begin
               if (pressed_s) begin
                  state_r <= PRESS_DB;
                  cnt_r   <= '0;
               end
            end
            PRESS_DB: begin
               if (!pressed_s) begin
                  state_r <= IDLE;
               end else if (cnt_r == CW'(DB_CYCLES - 1)) begin
                  state_r      <= PRESSED;
                  level_r      <= 1'b1;
                  press_r      <= 1'b1;
                  lcnt_r       <= '0;
                  long_fired_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            PRESSED: begin
               if (!pressed_s) begin
                  state_r <= RELEASE_DB;
                  cnt_r   <= '0;
               end else if (!long_fired_r) begin
                  if (lcnt_r == LW'(LONG_CYCLES - 1)) begin
                     long_r       <= 1'b1;
                     long_fired_r <= 1'b1;
                  end else begin
                     lcnt_r <= lcnt_r + LW'(1);
                  end
               end
            end
            RELEASE_DB: begin
               // A bounce back to pressed resumes the press with timers intact.
               if (pressed_s) begin
                  state_r <= PRESSED;
               end else if (cnt_r == CW'(DB_CYCLES - 1)) begin
                  state_r   <= IDLE;
                  level_r   <= 1'b0;
                  release_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               level_r <= 1'b0;
            end
         endcase
      end
   end

   assign btn_level     = level_r;
   assign press_pulse   = press_r;
   assign release_pulse = release_r;
   assign long_pulse    = long_r;

endmodule

// File: rtl/button_debounce_multi.sv
// N independent debounced button channels with press, release and
// long-press strobes; polarity normalised so 1 means pressed.
module button_debounce_multi
   import btn_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int CLK_HZ      = 50_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] long_pulse
);

   localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);

   generate
      if (CHANNELS < 1 || DB_CYCLES < 1 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_params
         $error("button_debounce_multi: invalid CHANNELS/DEBOUNCE_MS/LONG_MS");
      end
   endgenerate

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         debounce_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .ACTIVE_LOW  (ACTIVE_LOW)
         ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .btn_in        (btn_in[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i])
         );
      end
   endgenerate

endmodule
